prop_sequencer: RTL and testbench
=================================

Name: prop_sequencer

Overview:
Sequences forward and backward propagation through a chain of N_LAYERS unit layers. Each layer is driven by its own fd_prop/bk_prop enable. The block runs a forward pass one layer at a time (layer 0 first), holding each layer enabled for SETTLE_CYCLES so the oscillator-driven units can settle. In training mode it then runs a backward pass, last layer first. It sits between the host/training control logic and the unit array, and replaces hand-driven fd_prop/bk_prop strobes.

Parameters:
N_LAYERS, 4, number of unit layers in the chain (>=1)
SETTLE_CYCLES, 8, clk_in cycles each layer's enable is held (>=1)
LAYER_W, max(1,$clog2(N_LAYERS)), width of layer index (derived, not overridden)
CNT_W, max(1,$clog2(SETTLE_CYCLES)), width of settle counter (derived)

Ports:
clk_in  input  1  system clock; all logic on rising edge
rst_in  input  1  synchronous, active-high reset
start_in  input  1  request a pass; sampled only in IDLE
train_in  input  1  sampled with start_in; 1 = forward then backward pass, 0 = forward only
abort_in  input  1  cancel the pass in progress; sampled only in FWD/BWD
fd_prop_out  output  N_LAYERS  one-hot forward enable, bit i drives layer i fd_prop
bk_prop_out  output  N_LAYERS  one-hot backward enable, bit i drives layer i bk_prop
layer_out  output  LAYER_W  index of the currently enabled layer
phase_out  output  1  0 = forward, 1 = backward (valid while busy_out)
busy_out  output  1  high in FWD and BWD
done_out  output  1  one-cycle pulse when a pass completes
pass_count_out  output  16  count of completed (non-aborted) passes

Behaviour:
- All outputs registered. Reset (rst_in high at a clock edge) gives: state IDLE, fd_prop_out=0, bk_prop_out=0, layer_out=0, phase_out=0, busy_out=0, done_out=0, pass_count_out=0, settle counter=0, latched train=0. Reset wins over every other input in any state, including mid-pass.
- States: IDLE, FWD, BWD, DONE.
- IDLE:
  - start_in=1 at edge k: latch train_in, layer=0, counter=0, go to FWD.
  - From cycle k+1: fd_prop_out=1<<0, busy_out=1, phase_out=0.
  - abort_in is ignored in IDLE.
- FWD:
  - fd_prop_out=1<<layer, bk_prop_out=0, phase_out=0.
  - Counter increments each cycle.
  - When counter==SETTLE_CYCLES-1: reset counter to 0.
    - If layer<N_LAYERS-1: layer+1 and stay in FWD.
    - Else if latched train=1: go to BWD with layer=N_LAYERS-1.
    - Else: go to DONE.
  - Layer switches are gap-free: the next layer's bit rises on the same edge the previous bit falls.
- BWD:
  - bk_prop_out=1<<layer, fd_prop_out=0, phase_out=1.
  - Same counter rule. On the last count: if layer>0, layer-1; else go to DONE.
- DONE:
  - Lasts one cycle: done_out=1, busy_out=0, both enables 0.
  - pass_count_out increments on the edge entering DONE; it wraps 0xFFFF->0x0000.
  - Next state is IDLE. start_in is not accepted during the DONE cycle.
- Latency from the start_in edge k:
  - done_out is high in cycle k+1+N_LAYERS*SETTLE_CYCLES (forward only).
  - done_out is high in cycle k+1+2*N_LAYERS*SETTLE_CYCLES (train).
- Abort:
  - abort_in=1 in FWD/BWD: the next state is IDLE. All enables and busy_out clear on that edge.
  - No done_out pulse and no pass_count increment. layer_out returns to 0.
  - Abort has priority over a coincident settle completion or layer transition.
- Ignored inputs:
  - start_in while busy or in DONE is ignored; it is not queued.
  - train_in changes mid-pass have no effect.
- Invariants: at most one bit of fd_prop_out|bk_prop_out is set; fd_prop_out and bk_prop_out are never both nonzero.
- N_LAYERS=1: FWD is a single layer; in train mode BWD is a single layer.
- SETTLE_CYCLES=1: the layer advances every cycle.

Test Plan:
- Reset mid-pass: assert rst_in during FWD layer 2 -> next cycle every output 0, state IDLE, pass_count_out=0.
- Inference pass (N_LAYERS=4, SETTLE_CYCLES=8), start_in at edge k, train_in=0:
  - fd_prop_out 0001/0010/0100/1000, each for 8 cycles, with no gaps.
  - bk_prop_out stays 0.
  - done_out high only in cycle k+33; pass_count_out=1.
- Training pass, train_in=1:
  - fd_prop_out 0001→1000 over 32 cycles, then bk_prop_out 1000→0001 over 32 cycles.
  - phase_out goes 1 at cycle k+33.
  - done_out high at cycle k+65.
- Abort during BWD layer 1:
  - Next cycle: enables=0, busy_out=0.
  - done_out never pulses; pass_count_out unchanged.
  - A new start_in is accepted the following cycle.
- Ignored start: start_in held high continuously through a pass -> start_in during FWD/DONE has no effect; the next pass begins the cycle after DONE (one IDLE cycle).
- Counter wrap: preload via 65535 passes (or force) -> completing the next pass gives pass_count_out=0.

Source files
------------

// File: rtl/prop_sequencer.sv
// prop_sequencer
// Steps forward (and optionally backward) propagation enables through a chain
// of unit layers. Each layer stays enabled for SETTLE_CYCLES clocks so the
// oscillator-driven units can settle before the next layer is enabled.
// Every output is registered. The next output values are decoded from the
// next state, so the enables change on the same edge as the state register.

module prop_sequencer #(
  parameter int N_LAYERS      = 4,
  parameter int SETTLE_CYCLES = 8,
  localparam int LAYER_W      = (N_LAYERS > 1) ? $clog2(N_LAYERS) : 1,
  localparam int CNT_W        = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1
) (
  input  logic                clk_in,
  input  logic                rst_in,
  input  logic                start_in,
  input  logic                train_in,
  input  logic                abort_in,
  output logic [N_LAYERS-1:0] fd_prop_out,
  output logic [N_LAYERS-1:0] bk_prop_out,
  output logic [LAYER_W-1:0]  layer_out,
  output logic                phase_out,
  output logic                busy_out,
  output logic                done_out,
  output logic [15:0]         pass_count_out
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    FWD  = 2'd1,
    BWD  = 2'd2,
    DONE = 2'd3
  } state_t;

  localparam logic [LAYER_W-1:0] LAST_LAYER = LAYER_W'(N_LAYERS - 1);
  localparam logic [CNT_W-1:0]   LAST_CNT   = CNT_W'(SETTLE_CYCLES - 1);

  state_t               state;
  state_t               state_n;
  logic [CNT_W-1:0]     cnt;
  logic [CNT_W-1:0]     cnt_n;
  logic                 train_q;
  logic                 train_n;
  logic [LAYER_W-1:0]   layer_n;
  logic [15:0]          pass_n;
  logic                 settle_done;

  logic [N_LAYERS-1:0]  one_hot;
  logic [N_LAYERS-1:0]  fd_n;
  logic [N_LAYERS-1:0]  bk_n;
  logic                 phase_n;
  logic                 busy_n;
  logic                 done_n;

  assign settle_done = (cnt == LAST_CNT);

  // Next-state logic: start acceptance, settle counting, layer stepping and abort.
  always_comb begin
    state_n = state;
    cnt_n   = cnt;
    train_n = train_q;
    layer_n = layer_out;
    pass_n  = pass_count_out;

    case (state)
      IDLE: begin
        if (start_in) begin
          state_n = FWD;
          train_n = train_in;
          layer_n = '0;
          cnt_n   = '0;
        end
      end

      FWD: begin
        if (abort_in) begin
          state_n = IDLE;
          layer_n = '0;
          cnt_n   = '0;
        end else if (settle_done) begin
          cnt_n = '0;
          if (layer_out != LAST_LAYER) begin
            layer_n = layer_out + LAYER_W'(1);
          end else if (train_q) begin
            state_n = BWD;
            layer_n = LAST_LAYER;
          end else begin
            state_n = DONE;
            layer_n = '0;
            pass_n  = pass_count_out + 16'd1;
          end
        end else begin
          cnt_n = cnt + CNT_W'(1);
        end
      end

      BWD: begin
        if (abort_in) begin
          state_n = IDLE;
          layer_n = '0;
          cnt_n   = '0;
        end else if (settle_done) begin
          cnt_n = '0;
          if (layer_out != '0) begin
            layer_n = layer_out - LAYER_W'(1);
          end else begin
            state_n = DONE;
            layer_n = '0;
            pass_n  = pass_count_out + 16'd1;
          end
        end else begin
          cnt_n = cnt + CNT_W'(1);
        end
      end

      DONE: begin
        state_n = IDLE;
        layer_n = '0;
        cnt_n   = '0;
      end

      default: begin
        state_n = IDLE;
        layer_n = '0;
        cnt_n   = '0;
      end
    endcase
  end

  // Output decode from the next state so enables are registered alongside it.
  always_comb begin
    one_hot          = '0;
    one_hot[layer_n] = 1'b1;
    fd_n             = '0;
    bk_n             = '0;
    phase_n          = 1'b0;
    busy_n           = 1'b0;
    done_n           = 1'b0;

    case (state_n)
      FWD: begin
        fd_n   = one_hot;
        busy_n = 1'b1;
      end
      BWD: begin
        bk_n    = one_hot;
        phase_n = 1'b1;
        busy_n  = 1'b1;
      end
      DONE: begin
        done_n = 1'b1;
      end
      default: begin
        fd_n = '0;
      end
    endcase
  end

  // State, counter and registered outputs; reset overrides everything.
  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      state          <= IDLE;
      cnt            <= '0;
      train_q        <= 1'b0;
      layer_out      <= '0;
      fd_prop_out    <= '0;
      bk_prop_out    <= '0;
      phase_out      <= 1'b0;
      busy_out       <= 1'b0;
      done_out       <= 1'b0;
      pass_count_out <= 16'd0;
    end else begin
      state          <= state_n;
      cnt            <= cnt_n;
      train_q        <= train_n;
      layer_out      <= layer_n;
      fd_prop_out    <= fd_n;
      bk_prop_out    <= bk_n;
      phase_out      <= phase_n;
      busy_out       <= busy_n;
      done_out       <= done_n;
      pass_count_out <= pass_n;
    end
  end

endmodule

// File: tb/tb_prop_sequencer.sv
// tb_prop_sequencer
// Scoreboard bench: expected per-cycle output words are queued when a pass is
// launched (built from the pass timing) and compared one per clock.

module tb_prop_sequencer;

  localparam int N = 4;
  localparam int S = 8;
  localparam logic [31:0] FULL     = 32'hFFFF_FFFF;
  localparam logic [31:0] NO_LAYER = ~(32'h3 << 19);

  logic         clk_in = 1'b0;
  logic         rst_in;
  logic         start_in;
  logic         train_in;
  logic         abort_in;
  logic [N-1:0] fd_prop_out;
  logic [N-1:0] bk_prop_out;
  logic [1:0]   layer_out;
  logic         phase_out;
  logic         busy_out;
  logic         done_out;
  logic [15:0]  pass_count_out;

  int          total = 0;
  int          bad   = 0;
  logic [15:0] exp_pc;
  logic [31:0] exp_q[$];
  logic [31:0] mask_q[$];

  prop_sequencer #(.N_LAYERS(N), .SETTLE_CYCLES(S)) dut (
    .clk_in         (clk_in),
    .rst_in         (rst_in),
    .start_in       (start_in),
    .train_in       (train_in),
    .abort_in       (abort_in),
    .fd_prop_out    (fd_prop_out),
    .bk_prop_out    (bk_prop_out),
    .layer_out      (layer_out),
    .phase_out      (phase_out),
    .busy_out       (busy_out),
    .done_out       (done_out),
    .pass_count_out (pass_count_out)
  );

  // Free-running clock.
  always #5 clk_in = ~clk_in;

  function automatic logic [31:0] pack(input logic [3:0] fd, input logic [3:0] bk,
                                       input logic [1:0] layer, input logic phase,
                                       input logic busy, input logic done,
                                       input logic [15:0] pc);
    return {3'b000, fd, bk, layer, phase, busy, done, pc};
  endfunction

  function automatic logic [31:0] observed();
    return pack(fd_prop_out, bk_prop_out, layer_out, phase_out, busy_out, done_out,
                pass_count_out);
  endfunction

  task automatic checkOutput(input string tag, input logic [31:0] obs,
                             input logic [31:0] exp, input logic [31:0] mask);
    total++;
    if ((obs & mask) !== (exp & mask)) begin
      bad++;
      $display("[TB] FAIL %s at %0t: got=%h want=%h mask=%h", tag, $time, obs, exp, mask);
    end
  endtask

  task automatic applyStimulus(input logic start, input logic train, input logic abort);
    start_in = start;
    train_in = train;
    abort_in = abort;
  endtask

  task automatic push_exp(input logic [31:0] e, input logic [31:0] m);
    exp_q.push_back(e);
    mask_q.push_back(m);
  endtask

  task automatic push_idle(input logic [31:0] m);
    push_exp(pack(4'd0, 4'd0, 2'd0, 1'b0, 1'b0, 1'b0, exp_pc), m);
  endtask

  // Queue the expected words of one pass, optionally cut short after 'limit' cycles.
  task automatic push_pass(input logic train, input int limit);
    int n;
    logic [1:0] l;
    n = 0;
    for (int j = 0; j < N * S; j++) begin
      if (limit >= 0 && n >= limit) return;
      l = 2'(j / S);
      push_exp(pack(4'd1 << l, 4'd0, l, 1'b0, 1'b1, 1'b0, exp_pc), FULL);
      n++;
    end
    if (train) begin
      for (int j = 0; j < N * S; j++) begin
        if (limit >= 0 && n >= limit) return;
        l = 2'(N - 1 - j / S);
        push_exp(pack(4'd0, 4'd1 << l, l, 1'b1, 1'b1, 1'b0, exp_pc), FULL);
        n++;
      end
    end
    if (limit >= 0 && n >= limit) return;
    exp_pc = exp_pc + 16'd1;
    push_exp(pack(4'd0, 4'd0, 2'd0, 1'b0, 1'b0, 1'b1, exp_pc), NO_LAYER);
  endtask

  task automatic step(input string tag);
    logic [31:0] e;
    logic [31:0] m;
    @(posedge clk_in);
    #1;
    if (exp_q.size() == 0) begin
      checkOutput({tag, "_sb_empty"}, 32'(exp_q.size()), 32'd1, FULL);
    end else begin
      e = exp_q.pop_front();
      m = mask_q.pop_front();
      checkOutput(tag, observed(), e, m);
    end
  endtask

  task automatic drain(input string tag);
    while (exp_q.size() > 0) step(tag);
  endtask

  initial begin
    applyStimulus(1'b0, 1'b0, 1'b0);
    rst_in = 1'b1;
    exp_pc = 16'd0;
    repeat (2) @(posedge clk_in);
    #1;
    checkOutput("reset", observed(), 32'd0, FULL);
    rst_in = 1'b0;

    $display("[TB] inference pass");
    applyStimulus(1'b1, 1'b0, 1'b0);
    push_pass(1'b0, -1);
    step("inf");
    applyStimulus(1'b0, 1'b1, 1'b0);
    drain("inf");
    applyStimulus(1'b0, 1'b0, 1'b0);
    push_idle(NO_LAYER);
    step("inf_idle");

    $display("[TB] training pass");
    applyStimulus(1'b1, 1'b1, 1'b0);
    push_pass(1'b1, -1);
    step("trn");
    applyStimulus(1'b0, 1'b0, 1'b0);
    drain("trn");
    push_idle(NO_LAYER);
    step("trn_idle");

    $display("[TB] abort in backward layer 1, then restart");
    applyStimulus(1'b1, 1'b1, 1'b0);
    push_pass(1'b1, N * S + 2 * S + 3);
    step("abt_bwd");
    applyStimulus(1'b0, 1'b0, 1'b0);
    drain("abt_bwd");
    applyStimulus(1'b0, 1'b0, 1'b1);
    push_idle(FULL);
    step("abt_bwd_idle");
    applyStimulus(1'b1, 1'b0, 1'b0);
    push_pass(1'b0, -1);
    step("restart");
    applyStimulus(1'b0, 1'b0, 1'b0);
    drain("restart");
    push_idle(NO_LAYER);
    step("restart_idle");

    $display("[TB] abort on a layer transition edge");
    applyStimulus(1'b1, 1'b0, 1'b0);
    push_pass(1'b0, S);
    step("abt_edge");
    applyStimulus(1'b0, 1'b0, 1'b0);
    drain("abt_edge");
    applyStimulus(1'b0, 1'b0, 1'b1);
    push_idle(FULL);
    step("abt_edge_idle");

    $display("[TB] start held high through a pass");
    applyStimulus(1'b1, 1'b0, 1'b0);
    push_pass(1'b0, -1);
    drain("hold");
    push_idle(NO_LAYER);
    step("hold_idle");
    push_pass(1'b0, -1);
    step("hold2");
    applyStimulus(1'b0, 1'b0, 1'b0);
    drain("hold2");
    push_idle(NO_LAYER);
    step("hold2_idle");

    $display("[TB] abort ignored in idle");
    applyStimulus(1'b0, 1'b0, 1'b1);
    push_idle(NO_LAYER);
    push_idle(NO_LAYER);
    drain("idle_abort");
    applyStimulus(1'b1, 1'b0, 1'b1);
    push_pass(1'b0, -1);
    step("start_abort");
    applyStimulus(1'b0, 1'b0, 1'b0);
    drain("start_abort");
    push_idle(NO_LAYER);
    step("start_abort_idle");

    $display("[TB] reset during forward layer 2");
    applyStimulus(1'b1, 1'b1, 1'b0);
    push_pass(1'b1, 2 * S + 2);
    step("rst_mid");
    applyStimulus(1'b0, 1'b0, 1'b0);
    drain("rst_mid");
    rst_in = 1'b1;
    exp_pc = 16'd0;
    push_idle(FULL);
    step("rst_mid_out");
    rst_in = 1'b0;
    push_idle(FULL);
    step("rst_mid_after");

    $display("[TB] pass counter wrap");
    force dut.pass_count_out = 16'hFFFF;
    #1;
    release dut.pass_count_out;
    checkOutput("preload", 32'(pass_count_out), 32'h0000_FFFF, FULL);
    exp_pc = 16'hFFFF;
    applyStimulus(1'b1, 1'b0, 1'b0);
    push_pass(1'b0, -1);
    step("wrap");
    applyStimulus(1'b0, 1'b0, 1'b0);
    drain("wrap");
    push_idle(NO_LAYER);
    step("wrap_idle");
    checkOutput("wrap_zero", 32'(pass_count_out), 32'd0, FULL);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
